// File: rtl/sprite_blitter_if.sv
// Control, sprite ROM read port and frame buffer write port of the sprite blitter.
// The slave modport is the blitter's view; master is the view of the surrounding system.
interface sprite_blitter_if #(
    parameter int ROM_AW = 11,
    parameter int FB_AW  = 19
);
    logic              start;
    logic [9:0]        pos_x;
    logic [9:0]        pos_y;
    logic              flip;
    logic              busy;
    logic              done;
    logic [ROM_AW-1:0] rom_addr;
    logic [4:0]        rom_data;
    logic [FB_AW-1:0]  fb_addr;
    logic [4:0]        fb_data;
    logic              fb_we;
    logic              fb_ready;

    modport master (
        output start, pos_x, pos_y, flip, rom_data, fb_ready,
        input  busy, done, rom_addr, fb_addr, fb_data, fb_we
    );

    modport slave (
        input  start, pos_x, pos_y, flip, rom_data, fb_ready,
        output busy, done, rom_addr, fb_addr, fb_data, fb_we
    );
endinterface

// File: rtl/sprite_blitter.sv
// Copies one sprite from a synchronous ROM into the frame buffer at (pos_x, pos_y),
// skipping transparent (code 0) and off-screen pixels, optionally mirrored horizontally.
module sprite_blitter #(
    parameter int SPRITE_W = 24,
    parameter int SPRITE_H = 45,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    parameter int ROM_AW   = 11,
    parameter int FB_AW    = 19
) (
    input  logic            clk,
    input  logic            rst,
    sprite_blitter_if.slave bus
);

    localparam int SX_W = $clog2(SPRITE_W);
    localparam int SY_W = $clog2(SPRITE_H);
    localparam logic [SX_W-1:0] SX_LAST = SX_W'(SPRITE_W - 1);
    localparam logic [SY_W-1:0] SY_LAST = SY_W'(SPRITE_H - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_WRITE,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [SX_W-1:0]   sx_q, sx_d;
    logic [SY_W-1:0]   sy_q, sy_d;
    logic [9:0]        pos_x_q, pos_x_d;
    logic [9:0]        pos_y_q, pos_y_d;
    logic              flip_q, flip_d;
    logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;

    logic [SX_W-1:0]   col;
    logic [10:0]       tx;
    logic [10:0]       ty;
    logic              visible;
    logic              advance;
    logic              last_px;
    logic [FB_AW-1:0]  pix_addr;

    // 11-bit sums so a sprite hanging off the right/bottom edge never wraps
    assign tx       = 11'(pos_x_q) + 11'(sx_q);
    assign ty       = 11'(pos_y_q) + 11'(sy_q);
    assign visible  = (bus.rom_data != 5'd0) && (tx < 11'(SCREEN_W)) && (ty < 11'(SCREEN_H));
    assign advance  = (state_q == S_WRITE) && (!visible || bus.fb_ready);
    assign last_px  = (sx_q == SX_LAST) && (sy_q == SY_LAST);
    assign pix_addr = FB_AW'(ty) * FB_AW'(SCREEN_W) + FB_AW'(tx);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sx_q       <= '0;
            sy_q       <= '0;
            pos_x_q    <= '0;
            pos_y_q    <= '0;
            flip_q     <= 1'b0;
            rom_addr_q <= '0;
        end else begin
            sx_q       <= sx_d;
            sy_q       <= sy_d;
            pos_x_q    <= pos_x_d;
            pos_y_q    <= pos_y_d;
            flip_q     <= flip_d;
            rom_addr_q <= rom_addr_d;
        end
    end

    always_comb begin : next_state
        state_d = state_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        pos_x_d = pos_x_q;
        pos_y_d = pos_y_q;
        flip_d  = flip_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    pos_x_d = bus.pos_x;
                    pos_y_d = bus.pos_y;
                    flip_d  = bus.flip;
                    sx_d    = '0;
                    sy_d    = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_WRITE;
            S_WRITE: begin
                if (advance) begin
                    if (last_px) begin
                        sx_d    = '0;
                        sy_d    = '0;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_FETCH;
                        if (sx_q == SX_LAST) begin
                            sx_d = '0;
                            sy_d = sy_q + SY_W'(1);
                        end else begin
                            sx_d = sx_q + SX_W'(1);
                        end
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // The ROM address is loaded on the edge entering FETCH so data is ready in WRITE
    always_comb begin : rom_addr_next
        col        = flip_d ? (SX_LAST - sx_d) : sx_d;
        rom_addr_d = rom_addr_q;
        if (state_d == S_FETCH) begin
            rom_addr_d = ROM_AW'(sy_d) * ROM_AW'(SPRITE_W) + ROM_AW'(col);
        end
    end

    always_comb begin : outputs
        bus.busy     = (state_q != S_IDLE);
        bus.done     = (state_q == S_DONE);
        bus.rom_addr = rom_addr_q;
        bus.fb_we    = 1'b0;
        bus.fb_addr  = '0;
        bus.fb_data  = '0;
        if ((state_q == S_WRITE) && visible) begin
            bus.fb_we   = 1'b1;
            bus.fb_addr = pix_addr;
            bus.fb_data = bus.rom_data;
        end
    end

endmodule

// File: tb/tb_sprite_blitter.sv
// Randomised bench for sprite_blitter: a raster-walk reference model fills a scoreboard
// of expected frame buffer writes, and a negedge monitor checks every accepted write.
module tb_sprite_blitter;
    localparam int SW = 24;
    localparam int SH = 45;
    localparam int XW = 640;
    localparam int YH = 480;

    typedef struct packed {
        logic [18:0] addr;
        logic [4:0]  data;
        logic [10:0] ridx;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sprite_blitter_if #(.ROM_AW(11), .FB_AW(19)) bus ();

    sprite_blitter #(
        .SPRITE_W(SW), .SPRITE_H(SH), .SCREEN_W(XW), .SCREEN_H(YH),
        .ROM_AW(11), .FB_AW(19)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    logic [4:0] rom [0:2047];
    always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

    wr_t exp_q[$];
    wr_t mon_e;
    int  checks = 0;
    int  errors = 0;
    int  edge_cnt = 0;
    int  done_cnt = 0, done_edge = 0, stall_cnt = 0, wr_cnt = 0;
    int  first_addr = -1, first_ridx = -1, last_addr = -1;
    int  stall_left = 0;
    bit  rand_ready = 1'b0;
    bit  held_valid = 1'b0;
    logic [18:0] held_addr;
    logic [4:0]  held_data;
    int  start_edge;

    task automatic chk(input bit ok, input string name, input int act, input int req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    initial forever begin
        @(posedge clk);
        edge_cnt++;
    end

    // Write-acceptance driver: forced stalls on the first writes, or random back-pressure
    initial begin
        bus.fb_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_left > 0 && bus.fb_we) begin
                bus.fb_ready = 1'b0;
                stall_left--;
            end else if (rand_ready) begin
                bus.fb_ready = ($urandom_range(0, 3) != 0);
            end else begin
                bus.fb_ready = 1'b1;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (bus.fb_we) begin
                chk(bus.busy && !bus.done, "we_outside_write", int'(bus.busy), 1);
                if (held_valid)
                    chk(bus.fb_addr == held_addr && bus.fb_data == held_data,
                        "stall_hold", int'(bus.fb_addr), int'(held_addr));
                if (bus.fb_ready) begin
                    wr_cnt++;
                    if (wr_cnt == 1) begin
                        first_addr = int'(bus.fb_addr);
                        first_ridx = int'(bus.rom_addr);
                    end
                    last_addr = int'(bus.fb_addr);
                    if (exp_q.size() == 0) begin
                        chk(1'b0, "unexpected_write", int'(bus.fb_addr), -1);
                    end else begin
                        mon_e = exp_q.pop_front();
                        checks++;
                        if (bus.fb_addr != mon_e.addr || bus.fb_data != mon_e.data ||
                            bus.rom_addr != mon_e.ridx) begin
                            errors++;
                            $display("FAIL write: got addr %0d data %0d rom %0d, expected addr %0d data %0d rom %0d",
                                     bus.fb_addr, bus.fb_data, bus.rom_addr,
                                     mon_e.addr, mon_e.data, mon_e.ridx);
                        end
                    end
                end else begin
                    stall_cnt++;
                end
            end
            held_valid = bus.fb_we && !bus.fb_ready;
            held_addr  = bus.fb_addr;
            held_data  = bus.fb_data;
            if (bus.done) begin
                done_cnt++;
                done_edge = edge_cnt;
            end
        end
    end

    // Reference: raster walk over the sprite, mirror columns, drop transparent/off-screen
    task automatic build_expected(input int px, input int py, input bit fl);
        wr_t w;
        int idx, tx, ty;
        exp_q.delete();
        for (int y = 0; y < SH; y++) begin
            for (int x = 0; x < SW; x++) begin
                idx = y * SW + (fl ? (SW - 1 - x) : x);
                tx  = px + x;
                ty  = py + y;
                if (rom[idx] != 5'd0 && tx < XW && ty < YH) begin
                    w.addr = 19'(ty * XW + tx);
                    w.data = rom[idx];
                    w.ridx = 11'(idx);
                    exp_q.push_back(w);
                end
            end
        end
    endtask

    task automatic fill_rom(input int mode);
        for (int i = 0; i < 2048; i++) begin
            if (i >= SW * SH) rom[i] = 5'd0;
            else if (mode == 0) rom[i] = 5'($urandom_range(1, 31));
            else if (mode == 1) rom[i] = (i % 2 == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            else rom[i] = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        end
    endtask

    task automatic issue_start(input int px, input int py, input bit fl);
        done_cnt = 0; stall_cnt = 0; wr_cnt = 0;
        first_addr = -1; first_ridx = -1; last_addr = -1;
        @(posedge clk);
        #1;
        bus.pos_x = 10'(px); bus.pos_y = 10'(py); bus.flip = fl; bus.start = 1'b1;
        @(posedge clk);
        #1;
        start_edge = edge_cnt;
        bus.start = 1'b0;
        bus.pos_x = 10'($urandom); bus.pos_y = 10'($urandom); bus.flip = 1'($urandom);
        chk(bus.busy == 1'b1, "busy_after_start", int'(bus.busy), 1);
    endtask

    task automatic run_blit(input int px, input int py, input bit fl, input int stalls,
                            input bit rnd, input bit mid_start, input int req_n);
        int exp_n;
        build_expected(px, py, fl);
        exp_n = exp_q.size();
        stall_left = stalls;
        rand_ready = rnd;
        issue_start(px, py, fl);
        if (mid_start) begin
            repeat (300) @(posedge clk);
            #1;
            bus.pos_x = 10'd5; bus.pos_y = 10'd5; bus.flip = 1'b0; bus.start = 1'b1;
            @(posedge clk);
            #1;
            bus.start = 1'b0;
        end
        for (int i = 0; i < 8000 && done_cnt == 0; i++) @(posedge clk);
        if (done_cnt == 0) chk(1'b0, "done_timeout", 0, 1);
        else chk(done_edge - start_edge == 2 * SW * SH + stall_cnt, "done_latency",
                 done_edge - start_edge, 2 * SW * SH + stall_cnt);
        rand_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk(done_cnt == 1, "done_pulses", done_cnt, 1);
        chk(wr_cnt == exp_n, "write_count_model", wr_cnt, exp_n);
        if (req_n >= 0) chk(wr_cnt == req_n, "write_count", wr_cnt, req_n);
        chk(!bus.busy, "idle_after_done", int'(bus.busy), 0);
        $display("blit pos=(%0d,%0d) flip=%0d writes=%0d stalls=%0d cycles=%0d",
                 px, py, fl, wr_cnt, stall_cnt, done_edge - start_edge);
    endtask

    initial begin
        bus.start = 1'b0; bus.pos_x = '0; bus.pos_y = '0; bus.flip = 1'b0;
        fill_rom(0);
        #12;
        chk(bus.fb_we == 1'b0, "rst_fb_we", int'(bus.fb_we), 0);
        chk(bus.busy == 1'b0, "rst_busy", int'(bus.busy), 0);
        chk(bus.done == 1'b0, "rst_done", int'(bus.done), 0);
        chk(bus.rom_addr == '0, "rst_rom_addr", int'(bus.rom_addr), 0);
        chk(bus.fb_addr == '0, "rst_fb_addr", int'(bus.fb_addr), 0);
        chk(bus.fb_data == '0, "rst_fb_data", int'(bus.fb_data), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_blit(0, 0, 1'b0, 0, 1'b0, 1'b0, SW * SH);
        chk(first_addr == 0, "first_addr", first_addr, 0);
        chk(last_addr == 44 * XW + 23, "last_addr", last_addr, 44 * XW + 23);

        fill_rom(1);
        run_blit(0, 0, 1'b0, 0, 1'b0, 1'b0, 540);

        fill_rom(0);
        run_blit(630, 470, 1'b0, 0, 1'b0, 1'b0, 100);
        chk(last_addr == 307199, "clip_last_addr", last_addr, 307199);
        chk(first_addr == 470 * XW + 630, "clip_first_addr", first_addr, 470 * XW + 630);

        run_blit(0, 0, 1'b0, 3, 1'b0, 1'b0, SW * SH);
        chk(stall_cnt == 3, "stall_cycles", stall_cnt, 3);

        run_blit(100, 0, 1'b1, 0, 1'b0, 1'b1, SW * SH);
        chk(first_addr == 100, "flip_first_addr", first_addr, 100);
        chk(first_ridx == 23, "flip_first_rom", first_ridx, 23);

        // Abort a blit while a write is on the bus; outputs must clear before any clock
        build_expected(0, 0, 1'b0);
        issue_start(0, 0, 1'b0);
        repeat (101) @(posedge clk);
        #2;
        chk(bus.fb_we == 1'b1, "we_before_reset", int'(bus.fb_we), 1);
        rst = 1'b1;
        #1;
        chk(bus.fb_we == 1'b0, "abort_fb_we", int'(bus.fb_we), 0);
        chk(bus.busy == 1'b0, "abort_busy", int'(bus.busy), 0);
        chk(bus.done == 1'b0, "abort_done", int'(bus.done), 0);
        chk(bus.rom_addr == '0, "abort_rom_addr", int'(bus.rom_addr), 0);
        chk(bus.fb_addr == '0, "abort_fb_addr", int'(bus.fb_addr), 0);
        chk(bus.fb_data == '0, "abort_fb_data", int'(bus.fb_data), 0);
        repeat (2) @(posedge clk);
        #1;
        chk(done_cnt == 0, "abort_no_done", done_cnt, 0);
        exp_q.delete();
        rst = 1'b0;
        run_blit(0, 0, 1'b0, 0, 1'b0, 1'b0, SW * SH);

        for (int t = 0; t < 6; t++) begin
            fill_rom(2);
            run_blit(int'($urandom_range(0, 700)), int'($urandom_range(0, 520)),
                     1'($urandom), 0, 1'b1, 1'b0, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
